// File: rtl/match_timer_ctrl.sv
// match_timer_ctrl: round controller in front of the 3-digit countdown timer.
// Synchronises and edge-detects the four player buttons, lets the player set the
// round length while idle, sequences load/run/pause/round-end/game-over and
// counts completed rounds. All outputs are registered.
//
// Optional feature macro: AUTO_NEXT_ROUND_EN
//   defined     -> ROUND_END advances to LOAD by itself after AUTO_DELAY cycles
//                  (a start press still advances immediately)
//   not defined -> ROUND_END waits for a start press indefinitely
module match_timer_ctrl #(
    parameter int unsigned DEFAULT_TIME = 30,
    parameter int unsigned MIN_TIME     = 5,
    parameter int unsigned MAX_TIME_LIM = 199,
    parameter int unsigned STEP         = 5,
    parameter int unsigned NUM_ROUNDS   = 3,
    parameter int unsigned RST_HOLD     = 100_000_000,
    parameter int unsigned AUTO_DELAY   = 200_000_000
) (
    input  logic       orig_clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       time_out,
    output logic [7:0] max_time,
    output logic       time_en,
    output logic       timer_reset,
    output logic [3:0] round_cnt,
    output logic       game_over,
    output logic [2:0] state_code
);

    // One counter serves both the LOAD hold and the auto-advance delay, so it
    // is sized for the larger of the two.
    localparam int unsigned CNT_MAX = (RST_HOLD > AUTO_DELAY) ? RST_HOLD : AUTO_DELAY;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_PAUSE   = 3'd3,
        S_RND_END = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    // Button bit order inside the vectors below.
    localparam int B_START = 0;
    localparam int B_PAUSE = 1;
    localparam int B_UP    = 2;
    localparam int B_DOWN  = 3;

    logic [3:0]       btn_raw_s;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       prev_q;
    logic [3:0]       pulse_q;

    state_t           state_q,       state_d;
    logic [7:0]       max_time_q,    max_time_d;
    logic [3:0]       round_cnt_q,   round_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q,    hold_cnt_d;
    logic             time_en_q,     time_en_d;
    logic             timer_reset_q, timer_reset_d;
    logic             game_over_q,   game_over_d;

    logic [8:0]       max_up_sum_s;
    logic [7:0]       max_up_s;
    logic [7:0]       max_down_s;
    logic             start_s;
    logic             pause_s;
    logic             up_s;
    logic             down_s;

    assign btn_raw_s = {btn_down, btn_up, btn_pause, btn_start};
    assign start_s   = pulse_q[B_START];
    assign pause_s   = pulse_q[B_PAUSE];
    assign up_s      = pulse_q[B_UP];
    assign down_s    = pulse_q[B_DOWN];

    // Two-flop synchroniser plus rising-edge detector, giving a registered
    // single-cycle pulse per press three clocks after the pin rises.
    always_ff @(posedge orig_clk) begin
        if (reset) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            prev_q  <= 4'b0000;
            pulse_q <= 4'b0000;
        end else begin
            sync1_q <= btn_raw_s;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    // Saturating up/down candidates for the round length; 9-bit sum avoids wrap.
    always_comb begin
        max_up_sum_s = {1'b0, max_time_q} + 9'(STEP);
        if (max_up_sum_s > 9'(MAX_TIME_LIM)) begin
            max_up_s = 8'(MAX_TIME_LIM);
        end else begin
            max_up_s = max_up_sum_s[7:0];
        end
        if ({1'b0, max_time_q} < 9'(MIN_TIME + STEP)) begin
            max_down_s = 8'(MIN_TIME);
        end else begin
            max_down_s = max_time_q - 8'(STEP);
        end
    end

    // Next-state, round-length and round-count logic; outputs follow next state.
    always_comb begin
        state_d     = state_q;
        max_time_d  = max_time_q;
        round_cnt_d = round_cnt_q;
        hold_cnt_d  = hold_cnt_q;

        case (state_q)
            S_IDLE: begin
                // Simultaneous up and down cancel each other.
                if (up_s && !down_s) begin
                    max_time_d = max_up_s;
                end else if (down_s && !up_s) begin
                    max_time_d = max_down_s;
                end else begin
                    max_time_d = max_time_q;
                end
                if (start_s) begin
                    state_d    = S_LOAD;
                    hold_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // Any time_out here is left over from the previous round.
                if (hold_cnt_q == CNT_W'(RST_HOLD - 1)) begin
                    state_d    = S_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                // Timeout wins over a pause arriving in the same cycle.
                if (time_out) begin
                    state_d     = S_RND_END;
                    round_cnt_d = round_cnt_q + 4'd1;
                    hold_cnt_d  = '0;
                end else if (pause_s) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (pause_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_PAUSE;
                end
            end
            S_RND_END: begin
                if (round_cnt_q == 4'(NUM_ROUNDS)) begin
                    state_d = S_OVER;
                end else if (start_s) begin
                    state_d    = S_LOAD;
                    hold_cnt_d = '0;
                end else begin
`ifdef AUTO_NEXT_ROUND_EN
                    if (hold_cnt_q == CNT_W'(AUTO_DELAY - 1)) begin
                        state_d    = S_LOAD;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
`else
                    state_d = S_RND_END;
`endif
                end
            end
            S_OVER: begin
                if (start_s) begin
                    state_d     = S_IDLE;
                    round_cnt_d = 4'd0;
                end else begin
                    state_d = S_OVER;
                end
            end
            default: begin
                state_d    = S_IDLE;
                hold_cnt_d = '0;
            end
        endcase

        time_en_d     = (state_d == S_LOAD) || (state_d == S_RUN);
        timer_reset_d = (state_d == S_LOAD);
        game_over_d   = (state_d == S_OVER);
    end

    // Round FSM state, counters and registered outputs.
    always_ff @(posedge orig_clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            max_time_q    <= 8'(DEFAULT_TIME);
            round_cnt_q   <= 4'd0;
            hold_cnt_q    <= '0;
            time_en_q     <= 1'b0;
            timer_reset_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            max_time_q    <= max_time_d;
            round_cnt_q   <= round_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            time_en_q     <= time_en_d;
            timer_reset_q <= timer_reset_d;
            game_over_q   <= game_over_d;
        end
    end

    assign max_time    = max_time_q;
    assign time_en     = time_en_q;
    assign timer_reset = timer_reset_q;
    assign round_cnt   = round_cnt_q;
    assign game_over   = game_over_q;
    assign state_code  = state_q;

endmodule

// File: tb/tb_match_timer_ctrl.sv
// Testbench for match_timer_ctrl: a table of button/timeout steps with fixed
// expected results, a few hand-written multi-cycle sequences, then random
// stimulus compared cycle by cycle against a behavioural model of the game rules.
module tb_match_timer_ctrl;

    localparam int RST_HOLD   = 4;
    localparam int AUTO_DELAY = 6;
    localparam int NUM_ROUNDS = 2;
    localparam int STEP       = 5;

    logic       orig_clk = 1'b0;
    logic       reset;
    logic       btn_start, btn_pause, btn_up, btn_down, time_out;
    logic [7:0] max_time;
    logic       time_en, timer_reset, game_over;
    logic [3:0] round_cnt;
    logic [2:0] state_code;

    int checks   = 0;
    int failures = 0;

    match_timer_ctrl #(
        .RST_HOLD  (RST_HOLD),
        .AUTO_DELAY(AUTO_DELAY),
        .NUM_ROUNDS(NUM_ROUNDS),
        .STEP      (STEP)
    ) dut (
        .orig_clk   (orig_clk),
        .reset      (reset),
        .btn_start  (btn_start),
        .btn_pause  (btn_pause),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .time_out   (time_out),
        .max_time   (max_time),
        .time_en    (time_en),
        .timer_reset(timer_reset),
        .round_cnt  (round_cnt),
        .game_over  (game_over),
        .state_code (state_code)
    );

    always #5 orig_clk = ~orig_clk;

    // ---------------- behavioural model ----------------
    // Game phase uses the published state codes; a press reaches the game
    // logic three clocks after its pin rises (needs pin low the clock before).
    int         m_state, m_max, m_round, m_left;
    logic [3:0] m_hist [4];   // per button: bit j = pin value j+1 clocks ago

    task automatic model_step();
        logic [3:0] pins;
        logic [3:0] p;
        pins = {btn_down, btn_up, btn_pause, btn_start};
        if (reset) begin
            m_state = 0; m_max = 30; m_round = 0; m_left = 0;
            for (int b = 0; b < 4; b++) m_hist[b] = 4'b0000;
            return;
        end
        for (int b = 0; b < 4; b++) begin
            p[b]      = m_hist[b][2] & ~m_hist[b][3];
            m_hist[b] = {m_hist[b][2:0], pins[b]};
        end
        case (m_state)
            0: begin
                if (p[2] && !p[3]) m_max = (m_max + STEP > 199) ? 199 : m_max + STEP;
                else if (p[3] && !p[2]) m_max = (m_max - STEP < 5) ? 5 : m_max - STEP;
                if (p[0]) begin m_state = 1; m_left = RST_HOLD; end
            end
            1: begin
                m_left--;
                if (m_left == 0) m_state = 2;
            end
            2: begin
                if (time_out) begin m_state = 4; m_round++; m_left = AUTO_DELAY; end
                else if (p[1]) m_state = 3;
            end
            3: if (p[1]) m_state = 2;
            4: begin
                if (m_round == NUM_ROUNDS) m_state = 5;
                else if (p[0]) begin m_state = 1; m_left = RST_HOLD; end
`ifdef AUTO_NEXT_ROUND_EN
                else begin
                    m_left--;
                    if (m_left == 0) begin m_state = 1; m_left = RST_HOLD; end
                end
`endif
            end
            5: if (p[0]) begin m_state = 0; m_round = 0; end
            default: m_state = 0;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        chk("m_state",       32'(state_code),  32'(m_state));
        chk("m_max_time",    32'(max_time),    32'(m_max));
        chk("m_round_cnt",   32'(round_cnt),   32'(m_round));
        chk("m_time_en",     32'(time_en),     32'((m_state == 1) || (m_state == 2)));
        chk("m_timer_reset", 32'(timer_reset), 32'(m_state == 1));
        chk("m_game_over",   32'(game_over),   32'(m_state == 5));
    endtask

    // One clock: DUT and model both see the edge; return at the falling edge.
    task automatic tick();
        @(posedge orig_clk);
        model_step();
        @(negedge orig_clk);
    endtask

    task automatic press(input logic up, input logic dn, input logic st, input logic pa);
        btn_up = up; btn_down = dn; btn_start = st; btn_pause = pa;
        tick();
        btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
    endtask

    // ---------------- table of directed steps ----------------
    typedef struct {
        logic up, dn, st, pa, to;
        int   reps;
        int   e_state, e_max, e_round, e_en, e_go;
    } vec_t;

    vec_t tbl[15];
    int   n_tbl;
    int   cnt;

    initial begin
        // press,                         reps  state max round en go
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,  3,  0,  45, 0, 0, 0};
        tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 10,  0,   5, 0, 0, 0};
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,  1,  0,   5, 0, 0, 0};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,  4,  0,  25, 0, 0, 0};
        tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,  1,  2,  25, 0, 1, 0};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,  1,  3,  25, 0, 0, 0};
        tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,  1,  3,  25, 0, 0, 0};
        tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,  1,  3,  25, 0, 0, 0};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,  1,  2,  25, 0, 1, 0};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,  1,  4,  25, 1, 0, 0};
        tbl[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,  1,  2,  25, 1, 1, 0};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,  1,  5,  25, 2, 0, 1};
        tbl[12] = '{1'b0,1'b0,1'b1,1'b0,1'b0,  1,  0,  25, 0, 0, 0};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 36,  0, 199, 0, 0, 0};
        tbl[14] = '{1'b0,1'b1,1'b0,1'b0,1'b0,  1,  0, 194, 0, 0, 0};
`ifdef AUTO_NEXT_ROUND_EN
        n_tbl = 10;   // ROUND_END advances on its own from here on
`else
        n_tbl = 15;
`endif

        btn_start = 1'b0; btn_pause = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        time_out = 1'b0;
        reset = 1'b1;
        for (int b = 0; b < 4; b++) m_hist[b] = 4'b0000;
        m_state = 0; m_max = 0; m_round = 0; m_left = 0;
        @(negedge orig_clk);
        tick();
        tick();
        reset = 1'b0;
        chk("reset_state",    32'(state_code),  32'd0);
        chk("reset_max_time", 32'(max_time),    32'd30);
        chk("reset_round",    32'(round_cnt),   32'd0);
        chk("reset_outputs",  32'({time_en, timer_reset, game_over}), 32'd0);

        // Each step: press at clock k, time_out pulse at clock k+3 (the clock
        // the press takes effect), result sampled after clock k+8.
        for (int i = 0; i < n_tbl; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                press(tbl[i].up, tbl[i].dn, tbl[i].st, tbl[i].pa);
                tick();
                tick();
                time_out = tbl[i].to;
                tick();
                time_out = 1'b0;
                for (int c = 0; c < 5; c++) tick();
            end
            chk($sformatf("tbl%0d_state", i),     32'(state_code), 32'(tbl[i].e_state));
            chk($sformatf("tbl%0d_max_time", i),  32'(max_time),   32'(tbl[i].e_max));
            chk($sformatf("tbl%0d_round", i),     32'(round_cnt),  32'(tbl[i].e_round));
            chk($sformatf("tbl%0d_time_en", i),   32'(time_en),    32'(tbl[i].e_en));
            chk($sformatf("tbl%0d_game_over", i), 32'(game_over),  32'(tbl[i].e_go));
        end

        // Fresh game.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("seq_reset_max", 32'(max_time), 32'd30);

        // LOAD holds timer_reset for exactly RST_HOLD cycles, then RUN.
        press(1'b0, 1'b0, 1'b1, 1'b0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (timer_reset) cnt++;
            if (state_code == 3'd2) break;
        end
        chk("load_cycles",  32'(cnt),        32'(RST_HOLD));
        chk("run_state",    32'(state_code), 32'd2);
        chk("run_time_en",  32'(time_en),    32'd1);
        chk("run_trst_low", 32'(timer_reset),32'd0);

        // First timeout of the game.
        time_out = 1'b1;
        tick();
        time_out = 1'b0;
        chk("rnd_end_state", 32'(state_code), 32'd4);
        chk("rnd_end_round", 32'(round_cnt),  32'd1);
`ifdef AUTO_NEXT_ROUND_EN
        cnt = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (state_code == 3'd4) cnt++;
            else break;
        end
        chk("auto_delay",      32'(cnt),        32'(AUTO_DELAY));
        chk("auto_load_state", 32'(state_code), 32'd1);
`else
        for (int c = 0; c < 20; c++) tick();
        chk("rnd_end_waits", 32'(state_code), 32'd4);
`endif

        // Reset in the middle of LOAD.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) tick();
        press(1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) tick();
        chk("pre_rst_state", 32'(state_code),  32'd1);
        chk("pre_rst_trst",  32'(timer_reset), 32'd1);
        chk("pre_rst_max",   32'(max_time),    32'd35);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_state", 32'(state_code),  32'd0);
        chk("mid_rst_trst",  32'(timer_reset), 32'd0);
        chk("mid_rst_en",    32'(time_en),     32'd0);
        chk("mid_rst_max",   32'(max_time),    32'd30);

        // Random stimulus against the model.
        for (int c = 0; c < 3000; c++) begin
            check_model();
            btn_start = ($urandom_range(0, 5) == 0);
            btn_pause = ($urandom_range(0, 5) == 0);
            btn_up    = ($urandom_range(0, 3) == 0);
            btn_down  = ($urandom_range(0, 6) == 0);
            time_out  = ($urandom_range(0, 11) == 0);
            reset     = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;
        check_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
